// File: rtl/io_mmio_pkg.sv
// io_mmio_pkg: shared constants and register decode for the memory-mapped
// GPIO/PWM block. Holds the register offsets within the 256-byte IO window,
// the register-select enum, and a decode helper. Per-instance sizing
// parameters live on the io_mmio_pwm module.
package io_mmio_pkg;

  localparam logic [7:0] OFF_GPIO_OUT = 8'h00;
  localparam logic [7:0] OFF_GPIO_IN  = 8'h04;
  localparam logic [7:0] OFF_PWM_EN   = 8'h08;
  localparam logic [7:0] OFF_PWM_BASE = 8'h10;  // channel i: +8i period, +8i+4 duty
  localparam int         MAX_PWM      = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_GPIO_OUT,
    SEL_GPIO_IN,
    SEL_PWM_EN,
    SEL_PWM_PERIOD,
    SEL_PWM_DUTY
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [2:0] chan;
  } reg_dec_t;

  // Map a window offset to a register. Misaligned offsets, gaps and channels
  // beyond num_pwm decode to SEL_NONE (read 0, writes dropped).
  function automatic reg_dec_t decode_reg(input logic [7:0] off, input int num_pwm);
    reg_dec_t   d;
    logic [4:0] slot;
    d.sel  = SEL_NONE;
    d.chan = '0;
    slot   = off[7:3] - 5'd2;  // each channel occupies one 8-byte slot from 0x10
    if (off[1:0] != 2'b00) begin
      d.sel = SEL_NONE;
    end else if (off == OFF_GPIO_OUT) begin
      d.sel = SEL_GPIO_OUT;
    end else if (off == OFF_GPIO_IN) begin
      d.sel = SEL_GPIO_IN;
    end else if (off == OFF_PWM_EN) begin
      d.sel = SEL_PWM_EN;
    end else if (off >= OFF_PWM_BASE && int'(slot) < num_pwm) begin
      d.chan = slot[2:0];
      d.sel  = off[2] ? SEL_PWM_DUTY : SEL_PWM_PERIOD;
    end
    return d;
  endfunction

endpackage

// File: rtl/io_mmio_pwm_channel.sv
// pwm_channel: one PWM generator with shadow (bus-visible) and active
// period/duty registers. Active values load from shadow only at a period
// wrap or while disabled, so mid-period writes never chop a pulse.
// Ports:
//   clk, nrst               clock, async active-low reset
//   en                      channel enable
//   wr_period, wr_duty      shadow register write strobes
//   wdata                   write data (PWM_W bits)
//   shadow_period/_duty     shadow values for read-back
//   pwm                     registered PWM output
module pwm_channel #(
  parameter int PWM_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             wr_period,
  input  logic             wr_duty,
  input  logic [PWM_W-1:0] wdata,
  output logic [PWM_W-1:0] shadow_period,
  output logic [PWM_W-1:0] shadow_duty,
  output logic             pwm
);

  logic [PWM_W-1:0] act_period;
  logic [PWM_W-1:0] act_duty;
  logic [PWM_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let cnt/act_* updates race each other.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shadow_period <= '0;
      shadow_duty   <= '0;
      act_period    <= '0;
      act_duty      <= '0;
      cnt           <= '0;
      pwm           <= 1'b0;
    end else begin
      if (wr_period) shadow_period <= wdata;
      if (wr_duty)   shadow_duty   <= wdata;

      pwm <= en && (cnt < act_duty);

      // Disabled channels park at 0 with active tracking shadow; enabled
      // channels reload active only at the wrap (also every cycle if period 0).
      if (!en || cnt == act_period) begin
        cnt        <= '0;
        act_period <= shadow_period;
        act_duty   <= shadow_duty;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_mmio_pwm.sv
// io_mmio_pwm: memory-mapped GPIO and PWM peripheral sitting beside data
// memory. Accesses inside the 256-byte window at BASE_ADDR hit the register
// file; everything else (and all non-read cycles) returns data_from_mem.
// Ports:
//   clk, nrst                       clock, async active-low reset
//   write_mem, read_mem             core store/load strobes (both = store)
//   data_address, data_to_write     byte address, store data
//   data_from_mem                   data memory read data (pass-through)
//   data_read                       load data to core
//   gpio_in / gpio_out              async inputs (synchronised) / registered outputs
//   pwm_out                         registered PWM waveforms
//   io_hit                          current access targets the IO window
module io_mmio_pwm
  import io_mmio_pkg::*;
#(
  parameter int          GPIO_W    = 32,
  parameter int          NUM_PWM   = 4,
  parameter int          PWM_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              write_mem,
  input  logic              read_mem,
  input  logic [31:0]       data_address,
  input  logic [31:0]       data_to_write,
  input  logic [31:0]       data_from_mem,
  output logic [31:0]       data_read,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [NUM_PWM-1:0] pwm_out,
  output logic              io_hit
);

  logic        wr_acc;
  logic        rd_acc;
  reg_dec_t    dec;
  logic [31:0] reg_rdata;

  logic [GPIO_W-1:0]  gpio_out_q;
  logic [GPIO_W-1:0]  sync1;
  logic [GPIO_W-1:0]  sync2;
  logic [NUM_PWM-1:0] pwm_en;

  // Padded to MAX_PWM so the read mux can index with the raw 3-bit channel.
  logic [MAX_PWM-1:0][PWM_W-1:0] period_rd;
  logic [MAX_PWM-1:0][PWM_W-1:0] duty_rd;

  assign io_hit = (data_address[31:8] == BASE_ADDR[31:8]) && (write_mem || read_mem);
  assign wr_acc = io_hit && write_mem;
  assign rd_acc = io_hit && read_mem && !write_mem;  // read+write acts as a write
  assign dec    = decode_reg(data_address[7:0], NUM_PWM);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      gpio_out_q <= '0;
      sync1      <= '0;
      sync2      <= '0;
      pwm_en     <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      if (wr_acc && dec.sel == SEL_GPIO_OUT) gpio_out_q <= data_to_write[GPIO_W-1:0];
      if (wr_acc && dec.sel == SEL_PWM_EN)   pwm_en     <= data_to_write[NUM_PWM-1:0];
    end
  end

  assign gpio_out = gpio_out_q;

  for (genvar i = 0; i < MAX_PWM; i++) begin : g_pwm
    if (i < NUM_PWM) begin : g_ch
      pwm_channel #(.PWM_W(PWM_W)) u_ch (
        .clk           (clk),
        .nrst          (nrst),
        .en            (pwm_en[i]),
        .wr_period     (wr_acc && dec.sel == SEL_PWM_PERIOD && dec.chan == 3'(i)),
        .wr_duty       (wr_acc && dec.sel == SEL_PWM_DUTY && dec.chan == 3'(i)),
        .wdata         (data_to_write[PWM_W-1:0]),
        .shadow_period (period_rd[i]),
        .shadow_duty   (duty_rd[i]),
        .pwm           (pwm_out[i])
      );
    end else begin : g_unused
      assign period_rd[i] = '0;
      assign duty_rd[i]   = '0;
    end
  end

  // NOTE: default assigned first so every path drives reg_rdata; a missed
  // branch in combinational logic would otherwise infer a latch.
  always_comb begin
    reg_rdata = '0;
    case (dec.sel)
      SEL_GPIO_OUT:   reg_rdata = 32'(gpio_out_q);
      SEL_GPIO_IN:    reg_rdata = 32'(sync2);
      SEL_PWM_EN:     reg_rdata = 32'(pwm_en);
      SEL_PWM_PERIOD: reg_rdata = 32'(period_rd[dec.chan]);
      SEL_PWM_DUTY:   reg_rdata = 32'(duty_rd[dec.chan]);
      default:        reg_rdata = '0;
    endcase
  end

  assign data_read = rd_acc ? reg_rdata : data_from_mem;

endmodule

// File: tb/tb_io_mmio_pwm.sv
// Directed self-checking bench for io_mmio_pwm (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_io_mmio_pwm;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        write_mem = 1'b0;
  logic        read_mem = 1'b0;
  logic [31:0] data_address = '0;
  logic [31:0] data_to_write = '0;
  logic [31:0] data_from_mem = '0;
  logic [31:0] data_read;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio_out;
  logic [3:0]  pwm_out;
  logic        io_hit;

  int tests = 0;
  int fails = 0;

  io_mmio_pwm dut (
    .clk           (clk),
    .nrst          (nrst),
    .write_mem     (write_mem),
    .read_mem      (read_mem),
    .data_address  (data_address),
    .data_to_write (data_to_write),
    .data_from_mem (data_from_mem),
    .data_read     (data_read),
    .gpio_in       (gpio_in),
    .gpio_out      (gpio_out),
    .pwm_out       (pwm_out),
    .io_hit        (io_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle store; returns at the falling edge after the write edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    write_mem     = 1'b1;
    data_address  = a;
    data_to_write = d;
    @(negedge clk);
    write_mem = 1'b0;
  endtask

  // Combinational load check between clock edges.
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    read_mem     = 1'b1;
    data_address = a;
    #1;
    check(tag, data_read, exp);
    read_mem = 1'b0;
  endtask

  initial begin
    logic e;
    int   duty;

    // Reset state
    cyc(2);
    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_pwm_out", 32'(pwm_out), 32'h0);
    check("rst_io_hit", 32'(io_hit), 32'h0);
    nrst = 1'b1;
    cyc(1);

    // GPIO_OUT write and read-back
    check("gpio_out_pre", gpio_out, 32'h0);
    wr(BASE + 32'h00, 32'hA5);
    check("gpio_out_a5", gpio_out, 32'hA5);
    rd("rd_gpio_out", BASE + 32'h00, 32'h0000_00A5);
    read_mem = 1'b1; data_address = BASE + 32'h08; #1;
    check("io_hit_read", 32'(io_hit), 32'h1);
    read_mem = 1'b0;

    // GPIO_IN two-flop synchroniser latency
    gpio_in = 32'h3;
    rd("gpio_in_c1", BASE + 32'h04, 32'h0);
    cyc(1);
    rd("gpio_in_c2", BASE + 32'h04, 32'h0);
    cyc(1);
    rd("gpio_in_c3", BASE + 32'h04, 32'h3);

    // Unmapped in-window offsets
    wr(BASE + 32'h0C, 32'hFFFF_FFFF);
    rd("rd_gap_0c", BASE + 32'h0C, 32'h0);
    rd("rd_ch4_period", BASE + 32'h30, 32'h0);

    // Channel 0: period 9, duty 3; duty 3->7 written when counter is 5
    wr(BASE + 32'h10, 32'd9);
    wr(BASE + 32'h14, 32'd3);
    rd("rd_period0", BASE + 32'h10, 32'd9);
    rd("rd_duty0", BASE + 32'h14, 32'd3);
    wr(BASE + 32'h08, 32'h1);
    check("pwm0_enable_edge", 32'(pwm_out), 32'h0);
    for (int k = 1; k <= 40; k++) begin
      if (k == 26) begin
        write_mem = 1'b1; data_address = BASE + 32'h14; data_to_write = 32'd7;
      end
      cyc(1);
      write_mem = 1'b0;
      duty = (k <= 30) ? 3 : 7;
      e = ((k - 1) % 10) < duty;
      check($sformatf("pwm0_k%0d", k), 32'(pwm_out[0]), 32'(e));
    end
    rd("rd_duty0_new", BASE + 32'h14, 32'd7);

    // Outside-window access, read+write collision, idle pass-through
    data_from_mem = 32'hDEAD_BEEF;
    read_mem = 1'b1; data_address = 32'h0000_1000; #1;
    check("outside_data", data_read, 32'hDEAD_BEEF);
    check("outside_io_hit", 32'(io_hit), 32'h0);
    write_mem = 1'b1; data_address = BASE + 32'h04; data_to_write = 32'h5A; #1;
    check("rw_data", data_read, 32'hDEAD_BEEF);
    check("rw_io_hit", 32'(io_hit), 32'h1);
    cyc(1);
    write_mem = 1'b0; read_mem = 1'b0;
    data_address = BASE; #1;
    check("idle_passthru", data_read, 32'hDEAD_BEEF);
    rd("rw_gpio_in_kept", BASE + 32'h04, 32'h3);
    wr(32'h0000_1000, 32'h77);
    check("outside_wr_ignored", gpio_out, 32'hA5);
    rd("rw_gpio_out_kept", BASE + 32'h00, 32'hA5);

    // Boundaries: duty > period, period 0, duty 0
    wr(BASE + 32'h18, 32'd2);
    wr(BASE + 32'h1C, 32'd5);
    wr(BASE + 32'h20, 32'd0);
    wr(BASE + 32'h24, 32'd1);
    wr(BASE + 32'h28, 32'd4);
    wr(BASE + 32'h2C, 32'd0);
    wr(BASE + 32'h08, 32'hF);
    check("pwm123_enable_edge", 32'(pwm_out[3:1]), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      check($sformatf("pwm123_k%0d", k), 32'(pwm_out[3:1]), 32'b011);
    end

    // Asynchronous reset while pwm_out[0] is high
    for (int i = 0; i < 20 && !pwm_out[0]; i++) cyc(1);
    check("pwm0_high_before_rst", 32'(pwm_out[0]), 32'h1);
    #2 nrst = 1'b0;
    #1;
    check("rst_async_pwm", 32'(pwm_out), 32'h0);
    check("rst_async_gpio", gpio_out, 32'h0);
    cyc(2);
    nrst = 1'b1;
    cyc(1);
    rd("post_rst_gpio_out", BASE + 32'h00, 32'h0);
    rd("post_rst_pwm_en", BASE + 32'h08, 32'h0);
    rd("post_rst_period0", BASE + 32'h10, 32'h0);
    rd("post_rst_duty0", BASE + 32'h14, 32'h0);
    rd("post_rst_duty1", BASE + 32'h1C, 32'h0);
    cyc(3);
    check("post_rst_pwm_out", 32'(pwm_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_mmio_pwm.md
IO_MMIO_PWM -- requirements
Module: io_mmio_pwm

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
 GPIO_W, 32, GPIO output/input width (1..32)
 NUM_PWM, 4, PWM channel count (1..8)
 PWM_W, 16, PWM counter/period/duty width (2..32)
 BASE_ADDR, 32'hFFFF_FF00, IO window base; window is BASE_ADDR..BASE_ADDR+0xFF
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
 clk  input  1  single system clock, rising edge
 nrst  input  1  asynchronous active-low reset
 write_mem  input  1  store strobe from core
 read_mem  input  1  load strobe from core
 data_address  input  32  byte address of access
 data_to_write  input  32  store data
 data_from_mem  input  32  data returned by data memory
 data_read  output  32  load data to core
 gpio_in  input  GPIO_W  asynchronous external inputs
 gpio_out  output  GPIO_W  registered GPIO outputs
 pwm_out  output  NUM_PWM  registered PWM waveforms
 io_hit  output  1  access address lies in the IO window

Function
REQ-003 Register map (offsets from BASE_ADDR, word-aligned; unlisted in-window offsets read 0, writes ignored): 0x00 GPIO_OUT (RW), 0x04 GPIO_IN (RO), 0x08 PWM_EN (RW, bit i enables channel i), 0x10+8i PWM_PERIOD[i] (RW), 0x14+8i PWM_DUTY[i] (RW).
REQ-004 io_hit SHALL be combinational: 1 when data_address[31:8] equals BASE_ADDR[31:8] and (write_mem or read_mem), else 0.
REQ-005 Register writes SHALL take effect at the rising clk edge where write_mem=1 and the address matches; field width truncates data_to_write LSBs; read-back zero-extends.
REQ-006 data_read SHALL be combinational: register value when read_mem=1, write_mem=0 and io_hit=1; data_from_mem in all other cases.
REQ-007 write_mem and read_mem asserted together SHALL be treated as a write only; data_read = data_from_mem.
REQ-008 gpio_in SHALL pass through a two-flop synchronizer; GPIO_IN reads return the second-stage value (2-cycle latency from input change to readable value).
REQ-009 gpio_out SHALL equal the GPIO_OUT register, updating the cycle after the write edge.
REQ-010 Each PWM channel SHALL hold shadow (written) and active period/duty; the counter counts 0..active_period then wraps to 0.
REQ-011 pwm_out[i] SHALL be registered and equal 1 when enabled and counter < active_duty, else 0; duty > period gives constant 1, duty 0 gives constant 0.
REQ-012 Shadow-to-active copy SHALL occur only on the cycle the counter wraps (counter == active_period), so no truncated or glitched pulse results from mid-period writes.
REQ-013 While a channel is disabled: counter held at 0, pwm_out[i]=0, active registers track shadow every cycle; on enable the first period starts at counter 0 the next cycle.
REQ-014 active_period = 0 SHALL give counter fixed at 0 and a wrap every cycle (output 1 iff duty != 0).

Reset
REQ-015 nrst low SHALL asynchronously clear GPIO_OUT, PWM_EN, all shadow/active period and duty, all counters, both synchronizer stages and pwm_out to 0; gpio_out and pwm_out read 0 during reset.
REQ-016 Reset deasserted mid-period SHALL restart all channels from counter 0 with zeroed configuration; no prior state survives.

Structure
REQ-017 Package io_mmio_pkg SHALL hold register offset constants and the register-select enum; parameters stay on the module.
REQ-018 One sub-module pwm_channel (parameter PWM_W; shadow/active registers, counter, output flop) SHALL be instantiated NUM_PWM times via generate.

Verification
REQ-019 Write 0xA5 to BASE+0x00 -> gpio_out=0xA5 one cycle later; read BASE+0x00 returns 0x000000A5.
REQ-020 gpio_in 0->0x3 -> GPIO_IN read 0 for 2 cycles, 0x3 from cycle 3.
REQ-021 Channel 0 period=9, duty=3, enabled -> pwm_out[0] high 3 cycles, low 7, repeating every 10.
REQ-022 Mid-period duty write 3->7 at counter 5 -> current period keeps 3-high; next period 7-high.
REQ-023 Read of 0x0000_1000 with data_from_mem=0xDEADBEEF -> data_read=0xDEADBEEF, io_hit=0; simultaneous read+write at BASE+0x04 -> data_read=data_from_mem, no register change.
REQ-024 nrst pulsed while pwm_out[0]=1 -> pwm_out and gpio_out 0 immediately; after release all registers read 0.
